// File: rtl/xif_coproc_pkg.sv
// Shared decode constants, op/entry types and the instruction decoder for the XIF coprocessor.
// Optional min/max ops are enabled with the XIF_COPROC_MINMAX_EN macro.
package xif_coproc_pkg;

  localparam int MAX_ID_W = 8;

  localparam logic [6:0] OPCODE_CUSTOM0 = 7'b0001011;
  localparam logic [6:0] FUNCT7_ZERO    = 7'b0000000;
  localparam logic [2:0] F3_ADD         = 3'b000;
  localparam logic [2:0] F3_XOR         = 3'b001;
`ifdef XIF_COPROC_MINMAX_EN
  localparam logic [2:0] F3_MINU        = 3'b010;
  localparam logic [2:0] F3_MAXU        = 3'b011;
`endif

  typedef enum logic [1:0] {
    OP_ADD,
    OP_XOR,
    OP_MINU,
    OP_MAXU
  } op_e;

  typedef enum logic [1:0] {
    ENTRY_FREE,
    ENTRY_ISSUED,
    ENTRY_COMMITTED
  } entry_state_e;

  // Ids are stored zero-extended to MAX_ID_W so the entry type needs no parameter.
  typedef struct packed {
    entry_state_e          state;
    logic [MAX_ID_W-1:0]   id;
    logic [4:0]            rd;
    logic [31:0]           data;
  } entry_t;

  typedef struct packed {
    logic accept;
    op_e  op;
  } decode_t;

  function automatic decode_t decode_instr(input logic [31:0] instr,
                                           input logic [1:0]  rs_valid);
    decode_t d;
    d.accept = 1'b0;
    d.op     = OP_ADD;
    if (instr[6:0] == OPCODE_CUSTOM0 && instr[31:25] == FUNCT7_ZERO && rs_valid == 2'b11) begin
      case (instr[14:12])
        F3_ADD: begin d.accept = 1'b1; d.op = OP_ADD; end
        F3_XOR: begin d.accept = 1'b1; d.op = OP_XOR; end
`ifdef XIF_COPROC_MINMAX_EN
        F3_MINU: begin d.accept = 1'b1; d.op = OP_MINU; end
        F3_MAXU: begin d.accept = 1'b1; d.op = OP_MAXU; end
`endif
        default: ;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/xif_coproc_alu.sv
// Combinational datapath: op + rs0 + rs1 -> 32-bit result.
// Unsigned min/max exist only when XIF_COPROC_MINMAX_EN is defined.
module xif_coproc_alu
  import xif_coproc_pkg::*;
(
  input  op_e         op,
  input  logic [31:0] rs0,
  input  logic [31:0] rs1,
  output logic [31:0] data
);

  always_comb begin
    data = '0;
    case (op)
      OP_ADD:  data = rs0 + rs1;
      OP_XOR:  data = rs0 ^ rs1;
`ifdef XIF_COPROC_MINMAX_EN
      OP_MINU: data = (rs0 < rs1) ? rs0 : rs1;
      OP_MAXU: data = (rs0 < rs1) ? rs1 : rs0;
`endif
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/xif_coproc_scoreboard.sv
// In-order result buffer for an XIF coprocessor: accepts, computes, holds until commit/kill, retires in issue order.
// Build option: XIF_COPROC_MINMAX_EN adds minu/maxu.
module xif_coproc_scoreboard
  import xif_coproc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ID_W  = 4
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            issue_valid_i,
  output logic            issue_ready_o,
  input  logic [31:0]     issue_instr_i,
  input  logic [ID_W-1:0] issue_id_i,
  input  logic [31:0]     issue_rs0_i,
  input  logic [31:0]     issue_rs1_i,
  input  logic [1:0]      issue_rs_valid_i,
  output logic            issue_accept_o,
  output logic            issue_writeback_o,
  input  logic            commit_valid_i,
  input  logic [ID_W-1:0] commit_id_i,
  input  logic            commit_kill_i,
  output logic            result_valid_o,
  input  logic            result_ready_i,
  output logic [ID_W-1:0] result_id_o,
  output logic [4:0]      result_rd_o,
  output logic [31:0]     result_data_o,
  output logic            result_we_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  entry_t              entries_q [DEPTH];
  entry_t              entries_d [DEPTH];
  ptr_t                head_q, head_d;
  ptr_t                tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;

  decode_t             dec;
  logic [31:0]         alu_data;
  logic [MAX_ID_W-1:0] issue_id_ext;
  logic [MAX_ID_W-1:0] commit_id_ext;
  logic                issue_fire;
  logic                result_fire;
  logic                head_skip;
  logic                unused_instr_bits;

  assign dec               = decode_instr(issue_instr_i, issue_rs_valid_i);
  assign issue_id_ext      = MAX_ID_W'(issue_id_i);
  assign commit_id_ext     = MAX_ID_W'(commit_id_i);
  assign unused_instr_bits = ^issue_instr_i[24:15];

  assign issue_fire  = issue_valid_i && issue_ready_o && dec.accept;
  assign result_fire = result_valid_o && result_ready_i;
  // A killed entry leaves a FREE slot inside the ring; it is retired from the head one per cycle.
  assign head_skip   = (count_q != '0) && (entries_q[head_q].state == ENTRY_FREE);

  xif_coproc_alu u_alu (
    .op   (dec.op),
    .rs0  (issue_rs0_i),
    .rs1  (issue_rs1_i),
    .data (alu_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      entries_q <= '{default: '0};
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    entries_d = entries_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (commit_valid_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entries_q[i].state == ENTRY_ISSUED && entries_q[i].id == commit_id_ext) begin
          entries_d[i].state = commit_kill_i ? ENTRY_FREE : ENTRY_COMMITTED;
        end
      end
    end

    if (result_fire) begin
      entries_d[head_q].state = ENTRY_FREE;
      head_d = head_q + ptr_t'(1);
    end else if (head_skip) begin
      head_d = head_q + ptr_t'(1);
    end

    if (issue_fire) begin
      entries_d[tail_q] = '{state: ENTRY_ISSUED,
                            id:    issue_id_ext,
                            rd:    issue_instr_i[11:7],
                            data:  alu_data};
      tail_d = tail_q + ptr_t'(1);
    end

    count_d = count_q + CNT_W'(issue_fire) - CNT_W'(result_fire || head_skip);
  end

  // Space is judged on the registered count alone, so a pop this cycle frees room only next cycle.
  always_comb begin
    issue_ready_o     = count_q < CNT_W'(DEPTH);
    issue_accept_o    = dec.accept;
    issue_writeback_o = dec.accept;
    result_valid_o    = entries_q[head_q].state == ENTRY_COMMITTED;
    result_id_o       = '0;
    result_rd_o       = '0;
    result_data_o     = '0;
    result_we_o       = 1'b0;
    if (result_valid_o) begin
      result_id_o   = entries_q[head_q].id[ID_W-1:0];
      result_rd_o   = entries_q[head_q].rd;
      result_data_o = entries_q[head_q].data;
      result_we_o   = entries_q[head_q].rd != 5'd0;
    end
  end

endmodule

// File: doc/xif_coproc_scoreboard.md
XIF_COPROC_SCOREBOARD -- requirements
Module: xif_coproc_scoreboard

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set in-flight instruction buffer entries (power of two, 2..8).
REQ-002 Parameter ID_W, default 4, SHALL set XIF instruction id width.
REQ-003 clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 rst_i  in  1  reset, synchronous and active-high.
REQ-005 issue_valid_i  in  1  issue request from core; issue_ready_o  out  1  buffer can take a request.
REQ-006 issue_instr_i  in  32  offloaded instruction; issue_id_i  in  ID_W  instruction id.
REQ-007 issue_rs0_i, issue_rs1_i  in  32 each  operands; issue_rs_valid_i  in  2  operand valid flags.
REQ-008 issue_accept_o  out  1  instruction accepted; issue_writeback_o  out  1  will write rd.
REQ-009 commit_valid_i  in  1; commit_id_i  in  ID_W; commit_kill_i  in  1  commit/kill of an issued id.
REQ-010 result_valid_o  out  1; result_ready_i  in  1; result_id_o  out  ID_W; result_rd_o  out  5; result_data_o  out  32; result_we_o  out  1.

Function
REQ-011 Accepted: opcode 7'b0001011 (custom-0), funct7 0, supported funct3, both rs_valid bits set; anything else gets accept=0, writeback=0, no entry.
REQ-012 funct3 000=add, 001=xor (32-bit, wrap-around, no flags).
REQ-013 issue_ready_o SHALL be 1 iff occupancy < DEPTH, from registered count only; a same-cycle result pop SHALL NOT free space that cycle.
REQ-014 issue_accept_o/issue_writeback_o SHALL be combinational from issue_instr_i/issue_rs_valid_i, meaningful when issue_valid_i is high.
REQ-015 On issue handshake with accept: result computed that cycle, written with id, rd (instr[11:7]), committed=0 into tail entry; tail+1 mod DEPTH.
REQ-016 Entry states: FREE -> ISSUED (accepted issue) -> COMMITTED (commit_valid_i, id match, kill=0) -> FREE (result handshake); ISSUED -> FREE on matching kill.
REQ-017 Commit/kill to an id not in ISSUED state SHALL be ignored.
REQ-018 Results SHALL leave in issue order; result_valid_o = head entry COMMITTED, from registers only; earliest is cycle after commit.
REQ-019 Killed head entry SHALL be skipped, one cycle per entry; no result_valid_o for it.
REQ-020 While result_valid_o=1 and result_ready_i=0, all result_* SHALL hold stable.
REQ-021 result_we_o SHALL equal 1 when result_valid_o=1 and rd!=0, else 0.
REQ-022 Issue, commit and result handshake in one cycle SHALL all take effect.
REQ-023 Ids unique among in-flight entries; core guarantees it.

Reset
REQ-024 rst_i SHALL free all entries, zero pointers and count; next cycle issue_ready_o=1, result_valid_o=0, result_* zero.
REQ-025 Reset mid-operation SHALL drop in-flight entries; no later result for them.

Configuration
REQ-026 With XIF_COPROC_MINMAX_EN defined, funct3 010=minu, 011=maxu (unsigned 32-bit) SHALL be accepted.
REQ-027 Without XIF_COPROC_MINMAX_EN, funct3 010/011 SHALL get accept=0 and no min/max logic is built.

Structure
REQ-028 Package xif_coproc_pkg SHALL hold opcode/funct3 constants, the op enum and the entry struct (state, id, rd, data).
REQ-029 Sub-module xif_coproc_alu SHALL be combinational op+rs0+rs1 -> data; min/max under the macro.

Verification
REQ-030 Issue add id=3 rd=5 rs0=0xFFFFFFFF rs1=2, commit id 3 next cycle -> result_valid_o following cycle, data=0x00000001, rd=5, we=1.
REQ-031 Issue ids 1,2,3; kill 2, commit 1 and 3; ready=1 -> results id 1 then 3, none for 2.
REQ-032 Fill 4 entries without commit -> issue_ready_o=0; commit head and pop -> issue_ready_o=1 cycle after pop.
REQ-033 Committed head, result_ready_i=0 for 5 cycles -> result_* stable; ready=1 -> pops in one cycle.
REQ-034 Opcode 0110011 or rs_valid=2'b01 -> accept=0, occupancy unchanged; funct3 011 -> accept=0 without macro, maxu(5,9)=9 with it.
REQ-035 Two entries in flight, rst_i 1 cycle -> issue_ready_o=1, result_valid_o=0; late commits ignored.
